// File: rtl/regbank4_rd2.sv
// ---------------------------------------------------------------------------
// regbank4_rd2
//
// Four-entry register bank with one write port and two registered read
// ports. Read data appears one cycle after the address is presented. A write
// or clear landing on the same entry in that cycle is forwarded straight to
// the read register. A small clear engine zeroes the bank one entry per
// cycle on request. Entry 3 can optionally be a hardwired zero register,
// which follows the LEGv8 XZR convention.
//
// Parameters
//   WIDTH        data word width in bits
//   ZERO_REG_EN  when 1, entry 3 always reads 0 and writes to it are dropped
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   reset_n    asynchronous active-low reset
//   wr_en      write strobe
//   wr_addr    write entry index
//   wr_data    write data
//   rd_addr_a  read port A index
//   rd_addr_b  read port B index
//   rd_data_a  registered read data, port A
//   rd_data_b  registered read data, port B
//   clr_req    request to zero every entry
//   busy       high while the clear engine is zeroing entries
//   clr_done   single-cycle pulse once a clear has finished
//   wr_drop    high for one cycle after a write was discarded
// ---------------------------------------------------------------------------
module regbank4_rd2 #(
  parameter int WIDTH       = 64,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_addr_a,
  input  logic [1:0]       rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done,
  output logic             wr_drop
);

  localparam logic [1:0] ZERO_IDX = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic [WIDTH-1:0] mem [4];

  logic             clr_act;
  logic             wr_zero_tgt;
  logic             wr_acc;
  logic [WIDTH-1:0] rd_nxt_a;
  logic [WIDTH-1:0] rd_nxt_b;

  // busy and clr_done are decoded from the state register. They are therefore
  // registered, and they return to 0 as soon as reset is asserted.
  assign clr_act  = (state == CLEAR);
  assign busy     = clr_act;
  assign clr_done = (state == DONE);

  // A write reaches the array only when the clear engine is idle and the
  // target is not the hardwired zero entry.
  assign wr_zero_tgt = ZERO_REG_EN && (wr_addr == ZERO_IDX);
  assign wr_acc      = wr_en && !busy && !wr_zero_tgt;

  // Read forwarding, highest priority first: hardwired zero entry, the entry
  // being cleared this cycle, the write landing this cycle, then the stored
  // word.
  function automatic logic [WIDTH-1:0] read_sel(
    input logic [1:0]       addr,
    input logic [WIDTH-1:0] stored,
    input logic             clr_on,
    input logic [1:0]       clr_idx,
    input logic             wr_on,
    input logic [1:0]       wr_idx,
    input logic [WIDTH-1:0] wr_word
  );
    logic [WIDTH-1:0] val;
    if (ZERO_REG_EN && (addr == ZERO_IDX)) begin
      val = '0;
    end else if (clr_on && (clr_idx == addr)) begin
      val = '0;
    end else if (wr_on && (wr_idx == addr)) begin
      val = wr_word;
    end else begin
      val = stored;
    end
    return val;
  endfunction

  always_comb begin
    rd_nxt_a = read_sel(rd_addr_a, mem[rd_addr_a], clr_act, cnt, wr_acc, wr_addr, wr_data);
    rd_nxt_b = read_sel(rd_addr_b, mem[rd_addr_b], clr_act, cnt, wr_acc, wr_addr, wr_data);
  end

  // Clear sequencer. clr_req is honoured only in IDLE. The counter wraps
  // naturally from 3 to 0 when the engine leaves CLEAR.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = 2'd0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 2'd1;
        if (cnt == 2'd3) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Storage array. Writes and clears never coincide, because a write is
  // refused while the clear engine is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_acc) begin
        mem[wr_addr] <= wr_data;
      end
      if (clr_act) begin
        mem[cnt] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
      wr_drop   <= 1'b0;
    end else begin
      rd_data_a <= rd_nxt_a;
      rd_data_b <= rd_nxt_b;
      wr_drop   <= wr_en && !wr_acc;
    end
  end

endmodule

// File: tb/tb_regbank4_rd2.sv
// ---------------------------------------------------------------------------
// tb_regbank4_rd2
//
// Self-checking bench for regbank4_rd2 (WIDTH=64, ZERO_REG_EN=1). A reference
// model tracks the bank contents as a plain array. It tracks clear progress
// as "cycles since the clear started". Directed steps cover reset, bypass,
// the zero register, the clear sequence and reset during a clear. A random
// phase then follows.
// ---------------------------------------------------------------------------
module tb_regbank4_rd2;

  localparam int W = 64;

  logic         clk;
  logic         reset_n;
  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic [1:0]   rd_addr_a;
  logic [1:0]   rd_addr_b;
  logic [W-1:0] rd_data_a;
  logic [W-1:0] rd_data_b;
  logic         clr_req;
  logic         busy;
  logic         clr_done;
  logic         wr_drop;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state. A phase of -1 means no clear is running.
  // Phases 0..3 mean the clear is zeroing entry <phase>. Phase 4 is the
  // completion cycle.
  logic [W-1:0] m_mem [4];
  int           phase;
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  logic         exp_busy;
  logic         exp_done;
  logic         exp_drop;

  regbank4_rd2 #(
    .WIDTH      (W),
    .ZERO_REG_EN(1'b1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_done (clr_done),
    .wr_drop  (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    phase    = -1;
    exp_a    = '0;
    exp_b    = '0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_drop = 1'b0;
  endtask

  function automatic logic [W-1:0] predict(input logic [1:0] addr, input bit clearing,
                                           input int ph, input bit acc);
    if (addr == 2'd3) return '0;
    if (clearing && ph == int'(addr)) return '0;
    if (acc && wr_addr == addr) return wr_data;
    return m_mem[addr];
  endfunction

  // Advance the model by one rising edge, using the inputs currently applied.
  task automatic modelStep();
    bit clearing;
    bit acc;
    clearing = (phase >= 0) && (phase <= 3);
    acc      = wr_en && !clearing && (wr_addr != 2'd3);
    exp_a    = predict(rd_addr_a, clearing, phase, acc);
    exp_b    = predict(rd_addr_b, clearing, phase, acc);
    exp_drop = wr_en && !acc;
    if (acc) m_mem[wr_addr] = wr_data;
    if (clearing) m_mem[phase] = '0;
    if (phase == -1) begin
      if (clr_req) phase = 0;
    end else if (phase == 4) begin
      phase = -1;
    end else begin
      phase++;
    end
    exp_busy = (phase >= 0) && (phase <= 3);
    exp_done = (phase == 4);
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, "/rd_data_a"}, rd_data_a, exp_a);
    compare({tag, "/rd_data_b"}, rd_data_b, exp_b);
    compare({tag, "/busy"}, {63'd0, busy}, {63'd0, exp_busy});
    compare({tag, "/clr_done"}, {63'd0, clr_done}, {63'd0, exp_done});
    compare({tag, "/wr_drop"}, {63'd0, wr_drop}, {63'd0, exp_drop});
  endtask

  // Apply one cycle of inputs, clock it, update the model, then check 1 ns
  // after the edge.
  task automatic applyStimulus(input logic we, input logic [1:0] wa, input logic [W-1:0] wd,
                               input logic [1:0] ra, input logic [1:0] rb, input logic cr,
                               input string tag);
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    clr_req   = cr;
    @(posedge clk);
    if (reset_n) modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    int busy_cycles;
    int done_pulses;

    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
    modelReset();
    $display("[TB] start");

    // Reset hold with random inputs applied.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), {$urandom, $urandom},
                    2'($urandom), 2'($urandom), 1'($urandom), "reset_hold");
    end
    reset_n = 1'b1;

    // Basic write and read.
    applyStimulus(1'b1, 2'd0, 64'h1111, 2'd0, 2'd0, 1'b0, "wr0");
    applyStimulus(1'b1, 2'd2, 64'hABCD, 2'd0, 2'd0, 1'b0, "wr2");
    applyStimulus(1'b0, 2'd0, 64'h0,    2'd2, 2'd0, 1'b0, "rd20");
    compare("basic_a", rd_data_a, 64'hABCD);
    compare("basic_b", rd_data_b, 64'h1111);

    // Write-to-read bypass on both ports.
    applyStimulus(1'b1, 2'd1, 64'h55, 2'd1, 2'd1, 1'b0, "bypass");
    compare("bypass_a", rd_data_a, 64'h55);
    compare("bypass_b", rd_data_b, 64'h55);
    applyStimulus(1'b0, 2'd0, 64'h0, 2'd1, 2'd1, 1'b0, "bypass_after");
    compare("bypass_after_a", rd_data_a, 64'h55);

    // Zero register.
    applyStimulus(1'b1, 2'd3, 64'hFFFF, 2'd3, 2'd3, 1'b0, "zreg_wr");
    compare("zreg_drop", {63'd0, wr_drop}, 64'd1);
    compare("zreg_same", rd_data_a, 64'd0);
    applyStimulus(1'b0, 2'd0, 64'h0, 2'd3, 2'd3, 1'b0, "zreg_rd");
    compare("zreg_later", rd_data_b, 64'd0);

    // Clear sequence. The write presented together with clr_req is accepted.
    applyStimulus(1'b1, 2'd0, 64'd1, 2'd0, 2'd0, 1'b0, "fill0");
    applyStimulus(1'b1, 2'd1, 64'd2, 2'd0, 2'd0, 1'b0, "fill1");
    applyStimulus(1'b1, 2'd2, 64'd3, 2'd0, 2'd0, 1'b0, "fill2");
    busy_cycles = 0;
    done_pulses = 0;
    applyStimulus(1'b1, 2'd1, 64'h77, 2'd1, 2'd2, 1'b1, "clr_start");
    compare("clr_start_wr", rd_data_a, 64'h77);
    if (busy) busy_cycles++;
    applyStimulus(1'b1, 2'd0, 64'hDEAD, 2'd2, 2'd0, 1'b0, "clr_c1");
    compare("busy_wr_drop", {63'd0, wr_drop}, 64'd1);
    if (busy) busy_cycles++;
    applyStimulus(1'b0, 2'd0, 64'h0, 2'd2, 2'd0, 1'b0, "clr_c2");
    compare("clr_c2_entry2", rd_data_a, 64'd3);
    compare("clr_c2_entry0", rd_data_b, 64'd0);
    if (busy) busy_cycles++;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'd0, 64'h0, 2'($urandom), 2'($urandom), 1'b0, "clr_tail");
      if (busy) busy_cycles++;
      if (clr_done) done_pulses++;
    end
    compare("busy_cycles", 64'(busy_cycles), 64'd4);
    compare("done_pulses", 64'(done_pulses), 64'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'd0, 64'h0, 2'(i), 2'(i), 1'b0, "post_clr");
      compare("post_clr_zero", rd_data_a, 64'd0);
    end

    // Reset during the second cycle of a clear.
    applyStimulus(1'b1, 2'd0, 64'hA, 2'd0, 2'd0, 1'b0, "pre_rst0");
    applyStimulus(1'b1, 2'd1, 64'hB, 2'd0, 2'd0, 1'b0, "pre_rst1");
    applyStimulus(1'b0, 2'd0, 64'h0, 2'd1, 2'd0, 1'b1, "rst_clr_start");
    applyStimulus(1'b0, 2'd0, 64'h0, 2'd1, 2'd0, 1'b0, "rst_clr_c1");
    reset_n = 1'b0;
    modelReset();
    #1;
    compare("midrst_busy", {63'd0, busy}, 64'd0);
    compare("midrst_done", {63'd0, clr_done}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 2'd0, 64'h0, 2'd1, 2'd0, 1'b1, "midrst_hold");
    end
    reset_n = 1'b1;
    applyStimulus(1'b0, 2'd0, 64'h0, 2'd1, 2'd0, 1'b0, "rst_rd");
    compare("rst_entry1", rd_data_a, 64'd0);
    compare("rst_no_done", {63'd0, clr_done}, 64'd0);
    applyStimulus(1'b1, 2'd1, 64'h1234, 2'd0, 2'd0, 1'b0, "rst_wr");
    applyStimulus(1'b0, 2'd0, 64'h0, 2'd1, 2'd1, 1'b0, "rst_wr_rd");
    compare("rst_wr_works", rd_data_b, 64'h1234);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), 2'($urandom), {$urandom, $urandom},
                    2'($urandom), 2'($urandom), ($urandom_range(0, 15) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regbank4_rd2.md
Name: regbank4_rd2

Overview:
- Small 4-entry register bank. Its two read ports feed the 4:1 bit-select mux tree of the operand path: the 2-bit read address matches the mux select width, and each read data word is the per-bit mux input source.
- One write port, two read ports, and a registered (1-cycle) read with write-to-read bypass.
- A sequential clear engine zeroes the bank one entry per cycle on request.
- An optional hardwired zero register models the LEGv8 XZR convention.

Parameters:
- WIDTH, 64, data word width in bits.
- ZERO_REG_EN, 1, when 1 entry 3 always reads 0 and writes to it are discarded.

Ports:
- clk  input  1  single system clock, all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe.
- wr_addr  input  2  write entry index.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  2  read port A index.
- rd_addr_b  input  2  read port B index.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_data_b  output  WIDTH  registered read data, port B.
- clr_req  input  1  request to zero all entries.
- busy  output  1  high while the clear engine runs.
- clr_done  output  1  one-cycle pulse when a clear completes.
- wr_drop  output  1  registered flag: a write was discarded in the previous cycle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All 4 entries, rd_data_a and rd_data_b = 0.
  - busy = 0, clr_done = 0, wr_drop = 0.
  - FSM = IDLE, clear counter = 0.
  - Outputs hold these values until the first rising clk edge after reset_n rises.
- Write: on the edge where wr_en=1, busy=0, and the target is not zero-reg 3 (ZERO_REG_EN=1), entry[wr_addr] <= wr_data.
- Read latency is exactly 1 cycle: rd_data_x at edge N+1 reflects rd_addr_x sampled at edge N.
- Bypass priority for read port x, evaluated at edge N, highest first:
  1. ZERO_REG_EN=1 and rd_addr_x=3 -> 0.
  2. Clear engine is zeroing entry rd_addr_x this cycle -> 0.
  3. Accepted write to rd_addr_x this cycle -> wr_data.
  4. Otherwise -> stored entry.
- Both ports may read the same address, including while it is being written; both return identical values.
- wr_drop <= 1 for exactly one cycle after a write is discarded, either because busy=1 or because the target is zero-reg 3. Otherwise wr_drop <= 0.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: clr_req=1 -> CLEAR, cnt <= 0, busy <= 1. A write presented in the same cycle as clr_req is still accepted because busy is still 0, then is overwritten by the clear.
  - CLEAR: each cycle entry[cnt] <= 0 and cnt <= cnt+1. When cnt=3 -> DONE. This takes 4 cycles; busy=1 throughout.
  - DONE: busy <= 0, clr_done = 1 for this single cycle. Return to IDLE the next cycle.
  - clr_req is ignored outside IDLE; there is no queued re-clear. clr_req held high continuously re-triggers a clear from each IDLE.
- cnt is 2 bits and wraps 3 -> 0 naturally; no other wrap behaviour exists.
- Reads remain fully serviced during CLEAR. Entries not yet cleared return their old contents.
- Reset asserted mid-clear aborts immediately to the reset state. No clr_done pulse is emitted.

Test Plan:
- Reset hold: reset_n=0 with random inputs -> rd_data_a/b=0, busy=0, clr_done=0, wr_drop=0 for every cycle reset_n is low.
- Basic write/read:
  - Write 0x1111 to entry 0 and 0xABCD to entry 2 on consecutive cycles.
  - Then rd_addr_a=2, rd_addr_b=0 -> one cycle later rd_data_a=0xABCD, rd_data_b=0x1111.
- Bypass: wr_en=1, wr_addr=1, wr_data=0x55, rd_addr_a=rd_addr_b=1 in the same cycle -> both ports = 0x55 next cycle; entry 1 reads 0x55 thereafter.
- Zero register (ZERO_REG_EN=1): write 0xFFFF to entry 3 -> wr_drop=1 the next cycle; reading entry 3 returns 0 both in the same cycle and later.
- Clear sequence:
  - Fill entries 0..2 with 1, 2, 3, then pulse clr_req.
  - busy=1 for exactly 4 cycles, clr_done pulses on the following cycle.
  - A write during busy -> wr_drop=1 and no update.
  - Reading entry 2 in the second CLEAR cycle returns 3; after DONE all reads return 0.
- Reset mid-clear: drop reset_n during the second CLEAR cycle -> busy=0 immediately, all entries 0, no clr_done pulse; normal writes work after release.
